// File: rtl/sweep_pkg.sv
// Shared types and constants for the truth-table sweeper: FSM state encoding
// and the width of the settle down-counter.
package sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DRIVE  = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    localparam int SETTLE_W = 4;

endpackage

// File: rtl/settle_counter.sv
// Loadable down-counter with a zero flag; paces how long each vector is held
// before the function block output is sampled.
module settle_counter
    import sweep_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [SETTLE_W-1:0] load_val,
    input  logic                dec,
    output logic                zero
);

    logic [SETTLE_W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/sillyfunction.sv
// Small 3-input combinational block used as the default sweep target:
// y is high when b is low and a, c are not both high.
module sillyfunction (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic y
);

    assign y = ~b & (~a | ~c);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives a combinational block through all 2^N_IN inputs and captures its output
// into a truth table. Define SWEEP_CHECK_EN to add golden-table comparison ports.
module truth_table_sweeper
    import sweep_pkg::*;
#(
    parameter int N_IN   = 3,
    parameter int SETTLE = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [N_IN-1:0]        dut_in,
    input  logic                   dut_y,
    output logic [(1<<N_IN)-1:0]   tt_out
`ifdef SWEEP_CHECK_EN
    ,
    input  logic [(1<<N_IN)-1:0]   expected,
    output logic                   match,
    output logic [N_IN-1:0]        first_fail
`endif
);

    localparam int                  N_VEC       = 1 << N_IN;
    localparam logic [N_IN:0]       LAST_IDX    = (N_IN+1)'(N_VEC - 1);
    localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

    sweep_state_t        state_reg, state_next;
    logic [N_IN:0]       idx_reg;
    logic [N_VEC-1:0]    tt_reg, tt_next, capture_sel;
    logic                done_reg;
    logic                accept, advance, sample_en, cnt_load, cnt_dec, cnt_zero;
    logic [N_IN-1:0]     idx_lo;

    assign idx_lo    = idx_reg[N_IN-1:0];
    assign sample_en = (state_reg == SAMPLE);

    settle_counter u_settle (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (cnt_load),
        .load_val (SETTLE_LOAD),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        accept     = 1'b0;
        advance    = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_zero) begin
                    state_next = SAMPLE;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            SAMPLE: begin
                if (idx_reg == LAST_IDX) begin
                    state_next = DONE;
                end else begin
                    advance    = 1'b1;
                    cnt_load   = 1'b1;
                    state_next = DRIVE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // One-hot write enable: only the table bit addressed by idx captures dut_y.
    genvar gi;
    generate
        for (gi = 0; gi < N_VEC; gi++) begin : g_capture
            assign capture_sel[gi] = sample_en && (idx_lo == N_IN'(gi));
        end
    endgenerate

    assign tt_next = (tt_reg & ~capture_sel) | (capture_sel & {N_VEC{dut_y}});

    // done is registered off DONE so it lands in the cycle after busy drops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg  <= '0;
            tt_reg   <= '0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= (state_reg == DONE);
            if (accept) begin
                idx_reg <= '0;
                tt_reg  <= '0;
            end else begin
                tt_reg <= tt_next;
                if (advance) begin
                    idx_reg <= idx_reg + {{N_IN{1'b0}}, 1'b1};
                end
            end
        end
    end

    assign busy   = (state_reg != IDLE);
    assign done   = done_reg;
    assign dut_in = idx_lo;
    assign tt_out = tt_reg;

`ifdef SWEEP_CHECK_EN
    logic            match_reg, fail_seen_reg;
    logic [N_IN-1:0] first_fail_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_reg      <= 1'b0;
            fail_seen_reg  <= 1'b0;
            first_fail_reg <= '0;
        end else if (accept) begin
            match_reg      <= 1'b0;
            fail_seen_reg  <= 1'b0;
            first_fail_reg <= '0;
        end else if (sample_en && (dut_y != expected[idx_lo]) && !fail_seen_reg) begin
            fail_seen_reg  <= 1'b1;
            first_fail_reg <= idx_lo;
        end else if (state_reg == DONE) begin
            match_reg <= !fail_seen_reg;
        end
    end

    assign match      = match_reg;
    assign first_fail = first_fail_reg;
`endif

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper: SETTLE=1 and SETTLE=3 instances each
// sweep a sillyfunction block; SWEEP_CHECK_EN adds golden-table checks.
module tb_truth_table_sweeper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n, start1, start3;
    logic       busy1, done1, y1, busy3, done3, y3;
    logic [2:0] dut_in1, dut_in3;
    logic [7:0] tt1, tt3;
`ifdef SWEEP_CHECK_EN
    logic [7:0] exp1, exp3;
    logic       match1, match3;
    logic [2:0] ff1, ff3;
`endif

    sillyfunction u_f1 (.a(dut_in1[2]), .b(dut_in1[1]), .c(dut_in1[0]), .y(y1));
    sillyfunction u_f3 (.a(dut_in3[2]), .b(dut_in3[1]), .c(dut_in3[0]), .y(y3));

    truth_table_sweeper #(.N_IN(3), .SETTLE(1)) u_s1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
        .dut_in(dut_in1), .dut_y(y1), .tt_out(tt1)
`ifdef SWEEP_CHECK_EN
        , .expected(exp1), .match(match1), .first_fail(ff1)
`endif
    );

    truth_table_sweeper #(.N_IN(3), .SETTLE(3)) u_s3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .busy(busy3), .done(done3),
        .dut_in(dut_in3), .dut_y(y3), .tt_out(tt3)
`ifdef SWEEP_CHECK_EN
        , .expected(exp3), .match(match3), .first_fail(ff3)
`endif
    );

    bit         sel3;
    logic       m_busy, m_done, m_match;
    logic [2:0] m_dut_in, m_ff;
    logic [7:0] m_tt;

    always_comb begin
        m_busy   = sel3 ? busy3 : busy1;
        m_done   = sel3 ? done3 : done1;
        m_dut_in = sel3 ? dut_in3 : dut_in1;
        m_tt     = sel3 ? tt3 : tt1;
`ifdef SWEEP_CHECK_EN
        m_match  = sel3 ? match3 : match1;
        m_ff     = sel3 ? ff3 : ff1;
`else
        m_match  = 1'b0;
        m_ff     = 3'd0;
`endif
    end

    int vectors    = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, wanted %0h", name, act, exp);
        end
    endtask

    // Pulses start on the selected instance and waits (bounded) for done.
    task automatic run_sweep(input bit s3, input logic [7:0] golden,
                             output int done_cyc, output int busy_cyc,
                             output logic [7:0] tt_at_done, output logic match_at_done,
                             output logic [2:0] ff_at_done);
        sel3 = s3;
`ifdef SWEEP_CHECK_EN
        exp1 = golden;
        exp3 = golden;
`else
        if (golden === 8'hxx) $display("golden unknown");
`endif
        @(negedge clk);
        if (s3) start3 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        start3 = 1'b0;
        busy_cyc      = m_busy ? 1 : 0;
        done_cyc      = -1;
        tt_at_done    = 8'h00;
        match_at_done = 1'b0;
        ff_at_done    = 3'd0;
        for (int n = 1; n <= 100; n++) begin
            @(posedge clk); #1;
            if (m_done) begin
                done_cyc      = n;
                tt_at_done    = m_tt;
                match_at_done = m_match;
                ff_at_done    = m_ff;
                break;
            end
            if (m_busy) busy_cyc++;
        end
    endtask

    typedef struct {
        bit         s3;
        logic [7:0] golden;
        logic [7:0] exp_tt;
        int         exp_done;
        logic       exp_match;
        logic [2:0] exp_ff;
    } vec_t;

    vec_t tbl[6];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, wanted finish before 100000ns");
        $fatal(1, "watchdog");
    end

    initial begin
        int         dc, bc, ndone, first_d, second_d;
        logic [7:0] tt_d;
        logic       m_d;
        logic [2:0] ff_d;

        tbl[0] = '{1'b0, 8'h13, 8'h13, 17, 1'b1, 3'd0};
        tbl[1] = '{1'b1, 8'h13, 8'h13, 33, 1'b1, 3'd0};
        tbl[2] = '{1'b0, 8'h17, 8'h13, 17, 1'b0, 3'd2};
        tbl[3] = '{1'b1, 8'h12, 8'h13, 33, 1'b0, 3'd0};
        tbl[4] = '{1'b0, 8'h93, 8'h13, 17, 1'b0, 3'd7};
        tbl[5] = '{1'b0, 8'h00, 8'h13, 17, 1'b0, 3'd0};

        sel3   = 1'b0;
        rst_n  = 1'b0;
        start1 = 1'b0;
        start3 = 1'b0;
`ifdef SWEEP_CHECK_EN
        exp1 = 8'h00;
        exp3 = 8'h00;
`endif
        repeat (3) @(posedge clk);
        #1;
        check("reset_busy", 32'(busy1), 32'd0);
        check("reset_done", 32'(done1), 32'd0);
        check("reset_dut_in", 32'(dut_in1), 32'd0);
        check("reset_tt", 32'(tt1), 32'd0);
        check("reset_tt_s3", 32'(tt3), 32'd0);
`ifdef SWEEP_CHECK_EN
        check("reset_match", 32'(match1), 32'd0);
        check("reset_first_fail", 32'(ff1), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 6; i++) begin
            run_sweep(tbl[i].s3, tbl[i].golden, dc, bc, tt_d, m_d, ff_d);
            $display("sweep %0d: settle=%0d golden=%02h tt=%02h done_at=%0d busy=%0d match=%0d first_fail=%0d",
                     i, tbl[i].s3 ? 3 : 1, tbl[i].golden, tt_d, dc, bc, m_d, ff_d);
            check("done_cycle", 32'(dc), 32'(tbl[i].exp_done));
            check("busy_cycles", 32'(bc), 32'(tbl[i].exp_done));
            check("tt_out", 32'(tt_d), 32'(tbl[i].exp_tt));
`ifdef SWEEP_CHECK_EN
            check("match", 32'(m_d), 32'(tbl[i].exp_match));
            check("first_fail", 32'(ff_d), 32'(tbl[i].exp_ff));
`endif
            @(posedge clk); #1;
            check("done_one_cycle", 32'(m_done), 32'd0);
            check("idle_not_busy", 32'(m_busy), 32'd0);
            check("dut_in_hold_last", 32'(m_dut_in), 32'd7);
            check("tt_held", 32'(m_tt), 32'h13);
        end

        // SETTLE=3: each vector must be presented for exactly four cycles.
        sel3 = 1'b1;
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        for (int c = 0; c < 32; c++) begin
            check("walk_dut_in", 32'(dut_in3), 32'(c / 4));
            @(posedge clk); #1;
        end
        check("walk_no_early_done", 32'(done3), 32'd0);
        @(posedge clk); #1;
        check("walk_done_at_33", 32'(done3), 32'd1);
        check("walk_tt", 32'(tt3), 32'h13);
        $display("walk sweep: settle=3 tt=%02h", tt3);

        // start pulses while busy are ignored.
        sel3 = 1'b0;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1   = 1'b0;
        ndone    = 0;
        first_d  = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk); #1;
            start1 = (n == 4 || n == 8);
            if (done1) begin
                ndone++;
                if (first_d < 0) first_d = n;
            end
        end
        start1 = 1'b0;
        $display("ignore-start sweep: dones=%0d first_at=%0d tt=%02h", ndone, first_d, tt1);
        check("ignore_done_count", 32'(ndone), 32'd1);
        check("ignore_done_cycle", 32'(first_d), 32'd17);
        check("ignore_tt", 32'(tt1), 32'h13);

        // Asynchronous reset in the middle of a sweep.
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (8) @(posedge clk);
        #3;
        check("pre_reset_partial_tt", 32'(tt1), 32'h03);
        rst_n = 1'b0;
        #1;
        check("async_busy", 32'(busy1), 32'd0);
        check("async_dut_in", 32'(dut_in1), 32'd0);
        check("async_tt", 32'(tt1), 32'd0);
        ndone = 0;
        repeat (3) begin
            @(posedge clk); #1;
            if (done1) ndone++;
        end
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (done1) ndone++;
        end
        check("reset_no_done", 32'(ndone), 32'd0);
        run_sweep(1'b0, 8'h13, dc, bc, tt_d, m_d, ff_d);
        $display("post-reset sweep: tt=%02h done_at=%0d", tt_d, dc);
        check("post_reset_tt", 32'(tt_d), 32'h13);
        check("post_reset_done", 32'(dc), 32'd17);
        @(posedge clk); #1;

        // start held high: back-to-back sweeps separated by one IDLE cycle.
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk); #1;
        ndone    = 0;
        first_d  = -1;
        second_d = -1;
        for (int n = 1; n < 40; n++) begin
            @(posedge clk); #1;
            if (done1) begin
                ndone++;
                if (first_d < 0) first_d = n;
                else if (second_d < 0) second_d = n;
            end
            if (n == 17) check("held_gap_idle", 32'(busy1), 32'd0);
        end
        start1 = 1'b0;
        $display("held-start sweeps: dones=%0d at %0d and %0d", ndone, first_d, second_d);
        check("held_done_count", 32'(ndone), 32'd2);
        check("held_first_done", 32'(first_d), 32'd17);
        check("held_second_done", 32'(second_d), 32'd35);
        dc = -1;
        for (int n = 40; n <= 100; n++) begin
            @(posedge clk); #1;
            if (done1) begin
                dc = n;
                break;
            end
        end
        check("held_third_done", 32'(dc), 32'd53);
        check("held_tt", 32'(tt1), 32'h13);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
